// File: rtl/execute_mc.sv
// Execute stage: forwarding, single-cycle ALU, PC target and a multi-cycle
// shift-add multiplier, all feeding the EX/MEM pipeline register.
module execute_mc #(
    parameter int WIDTH = 64,
    parameter int CNTW  = 7
) (
    input  logic             clk,
    input  logic             resetl,
    input  logic             flush,
    input  logic             mem_stall,
    input  logic             valid_EX,
    input  logic [6:0]       ctrl_EX,
    input  logic [3:0]       ALUOp_EX,
    input  logic [4:0]       RD_EX,
    input  logic [4:0]       rn_EX,
    input  logic [4:0]       rm_EX,
    input  logic [WIDTH-1:0] RegOutA_EX,
    input  logic [WIDTH-1:0] RegOutB_EX,
    input  logic [WIDTH-1:0] SignExtImm_EX,
    input  logic [WIDTH-1:0] pc_EX,
    input  logic [WIDTH-1:0] aluout_MEM,
    input  logic             regwrite_MEM,
    input  logic [4:0]       rd_MEM,
    input  logic [WIDTH-1:0] memtoregout_WB,
    input  logic             regwrite_WB,
    input  logic [4:0]       rd_WB,
    output logic             ex_busy,
    output logic             valid_MEM,
    output logic [6:0]       ctrl_MEM,
    output logic             ALUzero_MEM,
    output logic [4:0]       RD_MEM,
    output logic [WIDTH-1:0] RegOutB_MEM,
    output logic [WIDTH-1:0] ALUout_MEM,
    output logic [WIDTH-1:0] PCtarget_MEM,
    output logic [WIDTH-1:0] pc_MEM
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_PSB = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_LSL = 4'b1001;
    localparam logic [3:0] OP_LSR = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNTW-1:0]  count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;

    logic [WIDTH-1:0] fwd_a;
    logic [WIDTH-1:0] fwd_b;
    logic [WIDTH-1:0] opnd_b;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] pc_tgt;
    logic [WIDTH-1:0] acc_step;
    logic             mul_req;
    logic             take;

    // MEM is the younger producer, so it wins over WB
    always_comb begin
        fwd_a = RegOutA_EX;
        if (regwrite_MEM && rd_MEM == rn_EX && rd_MEM != 5'd31)
            fwd_a = aluout_MEM;
        else if (regwrite_WB && rd_WB == rn_EX && rd_WB != 5'd31)
            fwd_a = memtoregout_WB;
    end

    always_comb begin
        fwd_b = RegOutB_EX;
        if (regwrite_MEM && rd_MEM == rm_EX && rd_MEM != 5'd31)
            fwd_b = aluout_MEM;
        else if (regwrite_WB && rd_WB == rm_EX && rd_WB != 5'd31)
            fwd_b = memtoregout_WB;
    end

    assign opnd_b = ctrl_EX[5] ? SignExtImm_EX : fwd_b;

    always_comb begin
        alu_res = '0;
        case (ALUOp_EX)
            OP_AND:  alu_res = fwd_a & opnd_b;
            OP_OR:   alu_res = fwd_a | opnd_b;
            OP_ADD:  alu_res = fwd_a + opnd_b;
            OP_SUB:  alu_res = fwd_a - opnd_b;
            OP_PSB:  alu_res = opnd_b;
            OP_LSL:  alu_res = fwd_a << opnd_b[SHW-1:0];
            OP_LSR:  alu_res = fwd_a >> opnd_b[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

    assign res      = (state == DONE) ? acc : alu_res;
    assign pc_tgt   = pc_EX + SignExtImm_EX;
    assign acc_step = acc + (mplier[0] ? mcand : '0);
    assign mul_req  = valid_EX && (ALUOp_EX == OP_MUL);

    // Real data is latched only by a single-cycle op or the MUL's final edge
    assign take = valid_EX &&
                  ((state == IDLE && !mul_req) || state == DONE);

    assign ex_busy = resetl &&
                     ((state == IDLE && mul_req) || state == BUSY);

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            state        <= IDLE;
            count        <= '0;
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            valid_MEM    <= 1'b0;
            ctrl_MEM     <= '0;
            ALUzero_MEM  <= 1'b0;
            RD_MEM       <= '0;
            RegOutB_MEM  <= '0;
            ALUout_MEM   <= '0;
            PCtarget_MEM <= '0;
            pc_MEM       <= '0;
        end else if (flush) begin
            state        <= IDLE;
            count        <= '0;
            valid_MEM    <= 1'b0;
            ctrl_MEM     <= '0;
            ALUzero_MEM  <= 1'b0;
            RD_MEM       <= '0;
            RegOutB_MEM  <= '0;
            ALUout_MEM   <= '0;
            PCtarget_MEM <= '0;
            pc_MEM       <= '0;
        end else if (!mem_stall) begin
            if (take) begin
                valid_MEM    <= 1'b1;
                ctrl_MEM     <= ctrl_EX;
                ALUzero_MEM  <= (res == '0);
                RD_MEM       <= RD_EX;
                RegOutB_MEM  <= fwd_b;
                ALUout_MEM   <= res;
                PCtarget_MEM <= pc_tgt;
                pc_MEM       <= pc_EX;
            end else begin
                valid_MEM    <= 1'b0;
                ctrl_MEM     <= '0;
                ALUzero_MEM  <= 1'b0;
                RD_MEM       <= '0;
                RegOutB_MEM  <= '0;
                ALUout_MEM   <= '0;
                PCtarget_MEM <= '0;
                pc_MEM       <= '0;
            end

            case (state)
                IDLE: begin
                    if (mul_req) begin
                        state  <= BUSY;
                        mcand  <= fwd_a;
                        mplier <= opnd_b;
                        acc    <= '0;
                        count  <= CNTW'(WIDTH);
                    end
                end
                BUSY: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count - CNTW'(1);
                    if (count == CNTW'(1))
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_mc.sv
// Randomized bench for execute_mc against a behavioural model of
// forwarding, ALU results and MUL occupancy.
module tb_execute_mc;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         resetl;
    logic         flush;
    logic         mem_stall;
    logic         valid_EX;
    logic [6:0]   ctrl_EX;
    logic [3:0]   ALUOp_EX;
    logic [4:0]   RD_EX, rn_EX, rm_EX;
    logic [W-1:0] RegOutA_EX, RegOutB_EX, SignExtImm_EX, pc_EX;
    logic [W-1:0] aluout_MEM;
    logic         regwrite_MEM;
    logic [4:0]   rd_MEM;
    logic [W-1:0] memtoregout_WB;
    logic         regwrite_WB;
    logic [4:0]   rd_WB;
    logic         ex_busy, valid_MEM, ALUzero_MEM;
    logic [6:0]   ctrl_MEM;
    logic [4:0]   RD_MEM;
    logic [W-1:0] RegOutB_MEM, ALUout_MEM, PCtarget_MEM, pc_MEM;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    execute_mc #(.WIDTH(W), .CNTW(7)) dut (
        .clk(clk), .resetl(resetl), .flush(flush), .mem_stall(mem_stall),
        .valid_EX(valid_EX), .ctrl_EX(ctrl_EX), .ALUOp_EX(ALUOp_EX),
        .RD_EX(RD_EX), .rn_EX(rn_EX), .rm_EX(rm_EX),
        .RegOutA_EX(RegOutA_EX), .RegOutB_EX(RegOutB_EX),
        .SignExtImm_EX(SignExtImm_EX), .pc_EX(pc_EX),
        .aluout_MEM(aluout_MEM), .regwrite_MEM(regwrite_MEM),
        .rd_MEM(rd_MEM), .memtoregout_WB(memtoregout_WB),
        .regwrite_WB(regwrite_WB), .rd_WB(rd_WB), .ex_busy(ex_busy),
        .valid_MEM(valid_MEM), .ctrl_MEM(ctrl_MEM),
        .ALUzero_MEM(ALUzero_MEM), .RD_MEM(RD_MEM),
        .RegOutB_MEM(RegOutB_MEM), .ALUout_MEM(ALUout_MEM),
        .PCtarget_MEM(PCtarget_MEM), .pc_MEM(pc_MEM)
    );

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] m_fwd(input logic [4:0] r,
                                           input logic [W-1:0] rf);
        if (regwrite_MEM && rd_MEM == r && rd_MEM != 5'd31)
            return aluout_MEM;
        if (regwrite_WB && rd_WB == r && rd_WB != 5'd31)
            return memtoregout_WB;
        return rf;
    endfunction

    function automatic logic [W-1:0] m_alu(input logic [3:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd7:    return b;
            4'd8:    return a * b;
            4'd9:    return a << (b % W);
            4'd10:   return a >> (b % W);
            default: return '0;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [6:0] c,
                         input logic [3:0] op, input logic [4:0] rd,
                         input logic [4:0] rn, input logic [4:0] rm,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] imm, input logic [W-1:0] pc);
        valid_EX = v; ctrl_EX = c; ALUOp_EX = op; RD_EX = rd;
        rn_EX = rn; rm_EX = rm; RegOutA_EX = a; RegOutB_EX = b;
        SignExtImm_EX = imm; pc_EX = pc;
    endtask

    task automatic no_fwd();
        regwrite_MEM = 1'b0; rd_MEM = '0; aluout_MEM = '0;
        regwrite_WB = 1'b0; rd_WB = '0; memtoregout_WB = '0;
    endtask

    task automatic check_mem(input string tag, input logic v,
                             input logic [6:0] c, input logic [4:0] rd,
                             input logic [W-1:0] rb, input logic [W-1:0] r,
                             input logic [W-1:0] pct, input logic [W-1:0] pcv);
        check({tag, ".valid"}, valid_MEM, v);
        check({tag, ".ctrl"}, ctrl_MEM, v ? c : 7'd0);
        check({tag, ".rd"}, RD_MEM, v ? rd : 5'd0);
        check({tag, ".zero"}, ALUzero_MEM, v && (r == '0));
        check({tag, ".regb"}, RegOutB_MEM, v ? rb : '0);
        check({tag, ".alu"}, ALUout_MEM, v ? r : '0);
        check({tag, ".pct"}, PCtarget_MEM, v ? pct : '0);
        check({tag, ".pc"}, pc_MEM, v ? pcv : '0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".busy"}, ex_busy, 1'b0);
        check_mem(tag, 1'b0, '0, '0, '0, '0, '0, '0);
    endtask

    // One non-MUL instruction through one edge
    task automatic single(input string tag);
        logic [W-1:0] a, b, o2, r;
        logic         v;
        #1;
        a  = m_fwd(rn_EX, RegOutA_EX);
        b  = m_fwd(rm_EX, RegOutB_EX);
        o2 = ctrl_EX[5] ? SignExtImm_EX : b;
        r  = m_alu(ALUOp_EX, a, o2);
        v  = valid_EX && !flush;
        check({tag, ".busy"}, ex_busy, 1'b0);
        @(posedge clk); #1;
        check_mem(tag, v, ctrl_EX, RD_EX, b, r,
                  pc_EX + SignExtImm_EX, pc_EX);
    endtask

    task automatic run_mul(input string tag, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int stall_at,
                           input int stall_len);
        int edges = 0;
        int busy = 0;
        bit done = 0;
        no_fwd();
        drive(1'b1, 7'b1000000, 4'b1000, 5'd9, 5'd5, 5'd6, a, b,
              '0, 64'h100);
        while (!done && edges < 200) begin
            #1;
            if (ex_busy) busy++;
            if (edges == 10) begin
                regwrite_MEM = 1'b1; rd_MEM = 5'd5;
                aluout_MEM = {$urandom, $urandom};
                regwrite_WB = 1'b1; rd_WB = 5'd5;
                memtoregout_WB = {$urandom, $urandom};
            end
            mem_stall = (stall_len > 0 && edges >= stall_at &&
                         edges < stall_at + stall_len);
            @(posedge clk); #1;
            edges++;
            if (valid_MEM) done = 1;
        end
        mem_stall = 1'b0;
        check({tag, ".edge"}, edges, 66 + stall_len);
        check({tag, ".busycyc"}, busy, 65 + stall_len);
        check_mem(tag, 1'b1, 7'b1000000, 5'd9, b, a * b,
                  64'h100, 64'h100);
        no_fwd();
        valid_EX = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] ops [12] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd9,
                                 4'd10, 4'd3, 4'd4, 4'd5, 4'd11, 4'd15};
        resetl = 1'b1; flush = 1'b0; mem_stall = 1'b0;
        no_fwd();
        drive(1'b1, 7'b1000000, 4'b1000, 5'd1, 5'd2, 5'd3,
              64'd7, 64'd9, '0, '0);
        #1 resetl = 1'b0;
        #1 check_zero("reset");
        #20 resetl = 1'b1;

        // Store
        drive(1'b1, 7'b0100010, 4'b0010, 5'd14, 5'd1, 5'd2,
              64'd6, 64'd0, 64'd4, 64'd0);
        single("store");
        check("store.k_alu", ALUout_MEM, 64'd10);
        check("store.k_pct", PCtarget_MEM, 64'd4);
        check("store.k_rd", RD_MEM, 5'd14);
        check("store.k_mw", ctrl_MEM[1], 1'b1);

        // Stall holds the EX/MEM register
        drive(1'b1, 7'b1000000, 4'b0110, 5'd4, 5'd1, 5'd2,
              64'd50, 64'd8, 64'd0, 64'd40);
        mem_stall = 1'b1;
        @(posedge clk); #1;
        check("stall.alu", ALUout_MEM, 64'd10);
        check("stall.rd", RD_MEM, 5'd14);
        mem_stall = 1'b0;
        single("stall_rel");

        // Forwarding priority
        regwrite_MEM = 1'b1; rd_MEM = 5'd3; aluout_MEM = 64'h55;
        regwrite_WB = 1'b1; rd_WB = 5'd3; memtoregout_WB = 64'h99;
        drive(1'b1, 7'b1100000, 4'b0010, 5'd1, 5'd3, 5'd4,
              64'd1, 64'd0, 64'd0, 64'd0);
        single("fwd_mem");
        check("fwd_mem.k", ALUout_MEM, 64'h55);
        rd_MEM = 5'd31;
        single("fwd_wb");
        check("fwd_wb.k", ALUout_MEM, 64'h99);
        regwrite_WB = 1'b0;
        single("fwd_reg");
        check("fwd_reg.k", ALUout_MEM, 64'd1);

        // CBZ
        no_fwd();
        drive(1'b1, 7'b0010000, 4'b0111, 5'd0, 5'd0, 5'd2,
              64'd5, 64'd0, -64'sd12, 64'hC);
        single("cbz");
        check("cbz.k_zero", ALUzero_MEM, 1'b1);
        check("cbz.k_pct", PCtarget_MEM, 64'd0);

        // Flush squashes a single-cycle op
        drive(1'b1, 7'b1000000, 4'b0010, 5'd3, 5'd1, 5'd2,
              64'd7, 64'd8, 64'd0, 64'd4);
        flush = 1'b1;
        single("flush1");
        flush = 1'b0;

        // Random single-cycle traffic
        for (int i = 0; i < 40; i++) begin
            logic [4:0] rn, rm;
            rn = 5'($urandom); rm = 5'($urandom);
            regwrite_MEM = 1'($urandom); regwrite_WB = 1'($urandom);
            rd_MEM = ($urandom % 2) ? rn : 5'($urandom);
            rd_WB = ($urandom % 2) ? rm : rn;
            aluout_MEM = {$urandom, $urandom};
            memtoregout_WB = {$urandom, $urandom};
            drive(($urandom % 8) != 0, 7'($urandom),
                  ops[$urandom % 12], 5'($urandom), rn, rm,
                  {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom});
            single($sformatf("rnd%0d", i));
        end
        no_fwd();

        // Multiplies
        run_mul("mul", 64'hFFFFFFFF, 64'd3, 0, 0);
        check("mul.k", ALUout_MEM, 64'h2FFFFFFFD);
        run_mul("mul_st", 64'hFFFFFFFF, 64'd3, 20, 3);
        check("mul_st.k", ALUout_MEM, 64'h2FFFFFFFD);
        for (int i = 0; i < 3; i++)
            run_mul($sformatf("mulr%0d", i), {$urandom, $urandom},
                    {$urandom, $urandom}, 0, 0);
        run_mul("mulr_st", {$urandom, $urandom}, {$urandom, $urandom},
                5 + int'($urandom % 40), 1 + int'($urandom % 4));

        // Flush mid-MUL
        drive(1'b1, 7'b1000000, 4'b1000, 5'd9, 5'd5, 5'd6,
              64'd11, 64'd13, '0, '0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("mflush.valid", valid_MEM, 1'b0);
        valid_EX = 1'b0;
        #1 check("mflush.busy", ex_busy, 1'b0);
        drive(1'b1, 7'b1000000, 4'b0010, 5'd7, 5'd1, 5'd2,
              64'd2, 64'd3, '0, '0);
        single("mflush_add");
        check("mflush_add.k", ALUout_MEM, 64'd5);

        // Reset mid-MUL
        drive(1'b1, 7'b1000000, 4'b1000, 5'd9, 5'd5, 5'd6,
              64'd11, 64'd13, '0, '0);
        repeat (5) @(posedge clk);
        #3 resetl = 1'b0;
        #1 check_zero("mreset");
        @(negedge clk) resetl = 1'b1;
        drive(1'b1, 7'b1000000, 4'b0010, 5'd7, 5'd1, 5'd2,
              64'd2, 64'd3, '0, 64'h20);
        single("mreset_add");
        check("mreset_add.k", ALUout_MEM, 64'd5);
        #2 resetl = 1'b0;
        #1 check_zero("reset_data");
        @(negedge clk) resetl = 1'b1;
        valid_EX = 1'b0;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
